// File: rtl/temp_display_driver.sv
// -----------------------------------------------------------------------------
// temp_display_driver
//
// Takes the 7-bit converted temperature and C/F flag from the conversion
// stage, turns it into BCD with a one-shift-per-cycle double-dabble engine,
// and drives a 4-digit multiplexed active-low seven-segment display.
//
// Display slots (by scan index):
//   0 -> an[0] unit letter ('C' or 'F')
//   1 -> an[1] ones
//   2 -> an[2] tens
//   3 -> an[3] hundreds
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous, active-high reset
//   data   in   7  temperature 0..127
//   unit   in   1  0 = Celsius, 1 = Fahrenheit
//   load   in   1  one-cycle capture strobe (ignored while busy)
//   busy   out  1  high while a conversion is in progress
//   done   out  1  one-cycle pulse when new digits are committed
//   an     out  4  anode enables, active-low, one-hot-low
//   seg    out  7  segments {g,f,e,d,c,b,a}, active-low
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   CNT_W        refresh counter width, 2**CNT_W >= REFRESH_DIV
//
// Optional feature macro: BLANK_LEADING_ZEROS_EN
//   When defined, a zero hundreds digit is blanked, and the tens digit is
//   blanked when both hundreds and tens are zero. Ones is always shown.
// -----------------------------------------------------------------------------
module temp_display_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] data,
   input  logic       unit,
   input  logic       load,
   output logic       busy,
   output logic       done,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [2:0]       ITER_LAST = 3'd6;

   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

   // Decimal digit to active-low gfedcba pattern; non-decimal codes blank.
   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble pre-shift correction for one BCD nibble.
   function automatic logic [3:0] dabble_adj(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   // ---------------------------------------------------------------------------
   // State and registers
   // ---------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [6:0]       src_q, src_d;          // captured data, shifted out MSB first
   logic [8:0]       bcd_q, bcd_d;          // {H, T[3:0], O[3:0]} accumulator
   logic [2:0]       iter_q, iter_d;
   logic             unit_cap_q, unit_cap_d;

   logic             hund_q, hund_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic             unit_q, unit_d;

   logic [CNT_W-1:0] refresh_q, refresh_d;
   logic [1:0]       idx_q, idx_d;

   // One double-dabble step: correct ones/tens, then shift in the next MSB.
   // The hundreds bit is only ever set by the final shift (value <= 127),
   // so the old bcd_q[8] is always zero when it falls off the top.
   logic [3:0] ones_adj, tens_adj;
   logic [8:0] bcd_step;

   always_comb begin
      ones_adj = dabble_adj(bcd_q[3:0]);
      tens_adj = dabble_adj(bcd_q[7:4]);
      bcd_step = {tens_adj, ones_adj, src_q[6]};
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      bcd_d      = bcd_q;
      iter_d     = iter_q;
      unit_cap_d = unit_cap_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      unit_d     = unit_q;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (load) begin
               src_d      = data;
               unit_cap_d = unit;
               bcd_d      = 9'd0;
               iter_d     = 3'd0;
               state_d    = S_CONVERT;
            end
         end

         S_CONVERT: begin
            busy  = 1'b1;
            bcd_d = bcd_step;
            src_d = {src_q[5:0], 1'b0};
            if (iter_q == ITER_LAST) begin
               state_d = S_COMMIT;
            end else begin
               iter_d = iter_q + 3'd1;
            end
         end

         S_COMMIT: begin
            // A load arriving here is dropped on purpose: no queueing.
            busy    = 1'b1;
            done    = 1'b1;
            hund_d  = bcd_q[8];
            tens_d  = bcd_q[7:4];
            ones_d  = bcd_q[3:0];
            unit_d  = unit_cap_q;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Refresh scan, free-running and independent of the FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      refresh_d = refresh_q + CNT_W'(1);
      idx_d     = idx_q;
      if (refresh_q == REF_LAST) begin
         refresh_d = '0;
         idx_d     = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         bcd_q      <= '0;
         iter_q     <= '0;
         unit_cap_q <= 1'b0;
         hund_q     <= 1'b0;
         tens_q     <= '0;
         ones_q     <= '0;
         unit_q     <= 1'b0;
         refresh_q  <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         bcd_q      <= bcd_d;
         iter_q     <= iter_d;
         unit_cap_q <= unit_cap_d;
         hund_q     <= hund_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         unit_q     <= unit_d;
         refresh_q  <= refresh_d;
         idx_q      <= idx_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Digit segment selection
   // ---------------------------------------------------------------------------
   logic [6:0] seg_hund, seg_tens, seg_ones, seg_unit;

   always_comb begin
      seg_hund = digit_to_seg({3'b000, hund_q});
      seg_tens = digit_to_seg(tens_q);
      seg_ones = digit_to_seg(ones_q);
      seg_unit = unit_q ? SEG_F : SEG_C;
`ifdef BLANK_LEADING_ZEROS_EN
      if (!hund_q) begin
         seg_hund = SEG_BLANK;
         if (tens_q == 4'd0) begin
            seg_tens = SEG_BLANK;
         end
      end
`else
      // All numeric slots always show their digit, leading zeros included.
`endif
   end

   always_comb begin
      an  = 4'b1111;
      seg = SEG_BLANK;
      case (idx_q)
         2'd0: begin an = 4'b1110; seg = seg_unit; end
         2'd1: begin an = 4'b1101; seg = seg_ones; end
         2'd2: begin an = 4'b1011; seg = seg_tens; end
         2'd3: begin an = 4'b0111; seg = seg_hund; end
         default: begin an = 4'b1111; seg = SEG_BLANK; end
      endcase
   end

endmodule

// File: tb/tb_temp_display_driver.sv
module tb_temp_display_driver;

   localparam int REFRESH_DIV = 4;
   localparam int CNT_W       = 3;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SC = 7'b1000110;
   localparam logic [6:0] SF = 7'b0001110;
`ifdef BLANK_LEADING_ZEROS_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = 7'b1000000;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] data = '0;
   logic       unit = 1'b0;
   logic       load = 1'b0;
   logic       busy, done;
   logic [3:0] an;
   logic [6:0] seg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   temp_display_driver #(.REFRESH_DIV(REFRESH_DIV), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .data(data), .unit(unit), .load(load),
      .busy(busy), .done(done), .an(an), .seg(seg)
   );

   typedef struct {
      logic [6:0] d;
      logic       u;
      logic [6:0] eh;
      logic [6:0] et;
      logic [6:0] eo;
      logic [6:0] el;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Pulse load for one edge; returns at the negedge of the following cycle.
   task automatic do_load(input logic [6:0] d, input logic u);
      data = d;
      unit = u;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Observe cycles N+1..N+ncyc after a load; count busy and done.
   task automatic watch(input int ncyc, output int busy_cnt, output int done_cnt,
                        output int done_at);
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      for (int k = 1; k <= ncyc; k++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         @(negedge clk);
      end
   endtask

   // Scan 16 cycles and compare the segments shown in each slot.
   task automatic check_display(input string nm, input logic [6:0] eh,
                                input logic [6:0] et, input logic [6:0] eo,
                                input logic [6:0] el);
      for (int k = 0; k < 16; k++) begin
         case (an)
            4'b1110: chk({nm, ".unit"}, 32'(seg), 32'(el));
            4'b1101: chk({nm, ".ones"}, 32'(seg), 32'(eo));
            4'b1011: chk({nm, ".tens"}, 32'(seg), 32'(et));
            4'b0111: chk({nm, ".hund"}, 32'(seg), 32'(eh));
            default: chk({nm, ".an_onehot"}, 32'(an), 32'hE);
         endcase
         @(negedge clk);
      end
   endtask

   initial begin
      int bc, dc, da;
      logic [3:0] exp_an;

      vecs[0] = '{7'd100, 1'b1, S1, S0, S0, SF};
      vecs[1] = '{7'd37,  1'b0, LZ, S3, S7, SC};
      vecs[2] = '{7'd0,   1'b0, LZ, LZ, S0, SC};
      vecs[3] = '{7'd42,  1'b1, LZ, S4, S2, SF};
      vecs[4] = '{7'd127, 1'b0, S1, S2, S7, SC};
      vecs[5] = '{7'd99,  1'b1, LZ, S9, S9, SF};
      vecs[6] = '{7'd58,  1'b0, LZ, S5, S8, SC};
      vecs[7] = '{7'd106, 1'b1, S1, S0, S6, SF};
      vecs[8] = '{7'd5,   1'b0, LZ, LZ, S5, SC};

      // Reset state and scan order
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      for (int k = 0; k < 20; k++) begin
         case ((k / REFRESH_DIV) % 4)
            0: exp_an = 4'b1110;
            1: exp_an = 4'b1101;
            2: exp_an = 4'b1011;
            default: exp_an = 4'b0111;
         endcase
         chk($sformatf("scan.an[%0d]", k), 32'(an), 32'(exp_an));
         if (k == 0) chk("rst.seg_c", 32'(seg), 32'(SC));
         if (k == 4) chk("rst.seg_ones", 32'(seg), 32'(S0));
         if (k == 12) chk("rst.seg_hund", 32'(seg), 32'(LZ));
         @(negedge clk);
      end

      // Table-driven conversions
      for (int i = 0; i < 9; i++) begin
         do_load(vecs[i].d, vecs[i].u);
         watch(12, bc, dc, da);
         chk($sformatf("v%0d.busy_cycles", i), 32'(bc), 32'd8);
         chk($sformatf("v%0d.done_count", i), 32'(dc), 32'd1);
         chk($sformatf("v%0d.done_cycle", i), 32'(da), 32'd8);
         check_display($sformatf("v%0d", i), vecs[i].eh, vecs[i].et,
                       vecs[i].eo, vecs[i].el);
      end

      // Display hold: input changes without load have no effect
      data = 7'd88;
      unit = 1'b1;
      repeat (3) @(negedge clk);
      check_display("hold", LZ, LZ, S5, SC);

      // Second load while busy is ignored
      do_load(7'd127, 1'b1);
      repeat (2) @(negedge clk);
      chk("busyload.busy", 32'(busy), 32'd1);
      do_load(7'd5, 1'b0);
      watch(14, bc, dc, da);
      chk("busyload.done_count", 32'(dc), 32'd1);
      check_display("busyload", S1, S2, S7, SF);

      // Held-high load: ignored during COMMIT, re-accepted on first idle cycle
      data = 7'd10;
      unit = 1'b0;
      load = 1'b1;
      @(negedge clk);
      data = 7'd20;
      unit = 1'b1;
      bc = 0; dc = 0; da = -1;
      for (int k = 1; k <= 20; k++) begin
         if (done) begin
            dc++;
            if (dc == 2) da = k;
         end
         if (k == 9) chk("held.commit_value_ones", 32'(dut.ones_q), 32'd0);
         @(negedge clk);
      end
      load = 1'b0;
      chk("held.done_count", 32'(dc), 32'd2);
      chk("held.second_done_cycle", 32'(da), 32'd17);
      repeat (12) @(negedge clk);
      check_display("held", LZ, S2, S0, SF);

      // Reset during the 4th CONVERT cycle aborts without a done pulse
      do_load(7'd99, 1'b1);
      repeat (3) @(negedge clk);
      chk("abort.busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort.an", 32'(an), 32'hE);
      chk("abort.busy", 32'(busy), 32'd0);
      watch(12, bc, dc, da);
      chk("abort.done_count", 32'(dc), 32'd0);
      check_display("abort", LZ, LZ, S0, SC);
      do_load(7'd42, 1'b0);
      watch(12, bc, dc, da);
      chk("after_abort.done_count", 32'(dc), 32'd1);
      check_display("after_abort", LZ, S4, S2, SC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time guard so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/temp_display_driver.md
Name: temp_display_driver

Overview:
- Consumes the 7-bit converted temperature and unit flag from the ROM-based temperature conversion stage and drives a 4-digit multiplexed seven-segment display.
- Converts binary to BCD with a sequential double-dabble engine, one shift per cycle, and holds the last committed value stable on the display.
- Scans four digits: hundreds, tens, ones and a unit letter ('C' or 'F').

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; minimum 2; 4 in simulation.
- CNT_W, 17: width of the refresh counter; must satisfy 2**CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  7  converted temperature, 0..127, from the conversion stage.
- unit  in  1  0 = Celsius, 1 = Fahrenheit; sampled together with data.
- load  in  1  one-cycle strobe requesting capture of data/unit.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- an  out  4  anode enables, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - FSM goes to IDLE; busy=0, done=0.
  - Shift register and iteration counter cleared.
  - Committed digits H=T=O=0, committed unit=0.
  - Refresh counter=0, digit index=0.
  - Outputs: an=4'b1110, seg=7'b1000110 ('C').
- FSM states:
  - IDLE: busy=0. On load=1, capture data and unit into holding registers, clear BCD accumulator and iteration counter, go to CONVERT.
  - CONVERT: busy=1. Each cycle, add 3 to every BCD nibble that is >=5, then shift left by one, bringing in the next data MSB. After exactly 7 iterations (counter 0..6), go to COMMIT.
  - COMMIT: busy=1. Copy BCD into H[0], T[3:0], O[3:0] and the captured unit into the committed unit register. Pulse done=1 for this cycle only. Return to IDLE.
- Latency: load sampled at edge N; busy high from N+1 through N+8; done high in cycle N+8; display shows the new value from cycle N+9.
- Load handling:
  - load while busy=1 is ignored; no queueing, no error.
  - load in the same cycle COMMIT returns to IDLE is ignored.
  - A held-high load is accepted again on the first cycle busy=0.
- Display hold: committed digits change only in COMMIT; data/unit changes outside a capture have no effect.
- Arithmetic: H is 1 bit, since 127 is the maximum. BCD accumulator is 9 bits ({H,T,O}) plus the 7-bit shift source.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, digit index increments 0->1->2->3->0.
  - Index mapping: 0 = an[0] unit letter, 1 = an[1] ones, 2 = an[2] tens, 3 = an[3] hundreds.
  - an and seg are combinational from the registered index and committed registers; exactly one an bit is low at all times after reset.
- Encodings (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 'C'=1000110, 'F'=0001110, blank=1111111
- Reset mid-conversion: abort immediately to the reset state; the partial result is discarded and done is not pulsed.
- Scan is independent of the FSM; a conversion never stalls or resets the refresh counter.

Optional Feature:
- Macro: BLANK_LEADING_ZEROS_EN.
- Defined:
  - Hundreds slot shows blank when H=0.
  - Tens slot shows blank when H=0 and T=0.
  - Ones is always shown.
- Not defined: all three numeric slots always show their digit, including leading '0'.

Test Plan:
- Reset, then release with REFRESH_DIV=4 -> an=1110, seg=1000110 for 4 cycles, then an=1101, seg=1000000; an cycles 1110->1101->1011->0111->1110 every 4 cycles.
- load with data=100, unit=1 -> busy high 8 cycles, done pulses in 8th cycle; slots show 'F','0','0','1'.
- load with data=37, unit=0 -> H=0, T=3, O=7, letter 'C'. Hundreds slot is blank with BLANK_LEADING_ZEROS_EN, 1000000 without it.
- load data=127, then a second load data=5 issued 3 cycles later while busy -> second load ignored; display shows 1,2,7; exactly one done pulse.
- load data=0 with BLANK_LEADING_ZEROS_EN -> hundreds and tens blank, ones=1000000.
- load data=99, then reset asserted in the 4th CONVERT cycle -> no done pulse; committed value 0 and letter 'C'; next load data=42 shows 4,2 correctly.
